// File: rtl/uart_rx_fifo_pkg.sv
// Shared register map for the uart receive FIFO: word offsets and field positions.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        RegData   = 2'd0,
        RegStatus = 2'd1,
        RegCtrl   = 2'd2,
        RegDrops  = 2'd3
    } reg_addr_e;

    localparam int unsigned DataEmptyBit   = 8;

    localparam int unsigned StatusEmptyBit = 0;
    localparam int unsigned StatusFullBit  = 1;
    localparam int unsigned StatusOvfBit   = 2;
    localparam int unsigned StatusCountLsb = 8;

    localparam int unsigned CtrlIeThrBit   = 0;
    localparam int unsigned CtrlIeOvfBit   = 1;
    localparam int unsigned CtrlThreshLsb  = 8;

    localparam int unsigned FlushBit       = 31;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Circular byte buffer with zero-wait head output; a pop frees a slot for a push in the same cycle.
module uart_rx_fifo_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            head
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [7:0]            mem_q [Depth];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
    assign count   = count_q;
    assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the uart: byte FIFO plus MMIO register window, overflow tracking and irq.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxnew,
    input  logic [7:0]  rxdata,
    input  logic [1:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        irq
);

    reg_addr_e               addr;
    logic                    full;
    logic                    empty;
    logic [DEPTH_LOG2:0]     count;
    logic [7:0]              head;
    logic                    pop;
    logic                    flush;
    logic                    drop;
    logic [8:0]              eff_thresh;
    logic                    thr_hit;

    logic [7:0]              thresh_q;
    logic                    ie_thr_q;
    logic                    ie_ovf_q;
    logic                    ovf_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;
    logic                    irq_q;

    assign addr  = reg_addr_e'(a);
    assign pop   = rd && (addr == RegData);
    assign flush = we && (addr == RegCtrl) && d[FlushBit];
    // A pop in the same cycle frees the slot, so only a push that cannot fit is lost.
    assign drop  = rxnew && !flush && full && !(pop && !empty);

    assign eff_thresh = (thresh_q == 8'h00) ? 9'd1 : {1'b0, thresh_q};
    assign thr_hit    = 9'(count) >= eff_thresh;

    uart_rx_fifo_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rxnew && !flush),
        .pop   (pop),
        .flush (flush),
        .wdata (rxdata),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q   <= 8'd1;
            ie_thr_q   <= 1'b0;
            ie_ovf_q   <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (we && (addr == RegCtrl)) begin
                thresh_q <= d[CtrlThreshLsb +: 8];
                ie_ovf_q <= d[CtrlIeOvfBit];
                ie_thr_q <= d[CtrlIeThrBit];
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (we && (addr == RegStatus) && d[StatusOvfBit]) begin
                ovf_q <= 1'b0;
            end
            if (we && (addr == RegDrops)) begin
                drop_cnt_q <= drop ? DROP_CNT_W'(1) : '0;
            end else if (drop && !(&drop_cnt_q)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
            irq_q <= (ie_thr_q && thr_hit) || (ie_ovf_q && ovf_q);
        end
    end

    assign irq = irq_q;

    always_comb begin
        spo = 32'h0;
        unique case (addr)
            RegData: begin
                spo[DataEmptyBit] = empty;
                spo[7:0]          = head;
            end
            RegStatus: begin
                spo[StatusCountLsb +: 8] = 8'(count);
                spo[StatusOvfBit]        = ovf_q;
                spo[StatusFullBit]       = full;
                spo[StatusEmptyBit]      = empty;
            end
            RegCtrl: begin
                spo[CtrlThreshLsb +: 8] = thresh_q;
                spo[CtrlIeOvfBit]       = ie_ovf_q;
                spo[CtrlIeThrBit]       = ie_thr_q;
            end
            RegDrops: spo = 32'(drop_cnt_q);
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for reset and basic push/pop, then corner sequences.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxnew;
    logic [7:0]  rxdata;
    logic [1:0]  a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rxnew;
        logic [7:0]  rxdata;
        logic        rd;
        logic [1:0]  a;
        logic [31:0] exp_spo;
        string       name;
    } vec_t;

    vec_t vecs[13];

    uart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .DROP_CNT_W (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxnew  (rxnew),
        .rxdata (rxdata),
        .a      (a),
        .d      (d),
        .we     (we),
        .rd     (rd),
        .spo    (spo),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic nw, logic [7:0] b, logic r, logic [1:0] ad,
                                logic [31:0] e, string n);
        vec_t v;
        v.rxnew = nw; v.rxdata = b; v.rd = r; v.a = ad; v.exp_spo = e; v.name = n;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [7:0] b);
        rxnew = 1'b1; rxdata = b;
        step();
        rxnew = 1'b0;
    endtask

    task automatic wr(logic [1:0] ad, logic [31:0] data);
        we = 1'b1; a = ad; d = data;
        step();
        we = 1'b0; d = '0;
    endtask

    task automatic reg_chk(logic [1:0] ad, logic [31:0] exp, string name);
        a = ad;
        #1;
        chk(name, spo, exp);
    endtask

    task automatic pop_chk(logic [31:0] exp, string name);
        a = 2'd0; rd = 1'b1;
        #1;
        chk(name, spo, exp);
        step();
        rd = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 8'h00, 0, 2'd0, 32'h100, "rst_data");
        vecs[1]  = mk(0, 8'h00, 0, 2'd1, 32'h001, "rst_status");
        vecs[2]  = mk(0, 8'h00, 0, 2'd2, 32'h100, "rst_ctrl");
        vecs[3]  = mk(0, 8'h00, 0, 2'd3, 32'h000, "rst_drops");
        vecs[4]  = mk(1, 8'h41, 0, 2'd0, 32'h100, "push41_empty");
        vecs[5]  = mk(1, 8'h42, 0, 2'd0, 32'h041, "push42_head");
        vecs[6]  = mk(1, 8'h43, 0, 2'd1, 32'h200, "push43_status");
        vecs[7]  = mk(0, 8'h00, 0, 2'd1, 32'h300, "status_cnt3");
        vecs[8]  = mk(0, 8'h00, 1, 2'd0, 32'h041, "pop41");
        vecs[9]  = mk(0, 8'h00, 1, 2'd0, 32'h042, "pop42");
        vecs[10] = mk(0, 8'h00, 1, 2'd0, 32'h043, "pop43");
        vecs[11] = mk(0, 8'h00, 1, 2'd0, 32'h100, "pop_empty");
        vecs[12] = mk(0, 8'h00, 0, 2'd1, 32'h001, "status_after_pops");

        rst = 1'b1; rxnew = 1'b0; rxdata = '0; a = '0; d = '0; we = 1'b0; rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 13; i++) begin
            rxnew = vecs[i].rxnew; rxdata = vecs[i].rxdata; rd = vecs[i].rd; a = vecs[i].a;
            #1;
            chk(vecs[i].name, spo, vecs[i].exp_spo);
            step();
            rxnew = 1'b0; rd = 1'b0;
        end

        // Overflow: 20 pushes into 16 slots.
        for (int i = 0; i < 20; i++) push(8'(i));
        reg_chk(2'd1, 32'h1006, "ovf_status");
        reg_chk(2'd3, 32'h4, "ovf_drops");
        for (int i = 0; i < 16; i++) pop_chk(32'(i), "ovf_drain");
        reg_chk(2'd1, 32'h005, "drained_status");
        wr(2'd1, 32'h4);
        reg_chk(2'd1, 32'h001, "ovf_clear");
        wr(2'd3, 32'h0);
        reg_chk(2'd3, 32'h0, "drops_clear");

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        rxnew = 1'b1; rxdata = 8'h55;
        pop_chk(32'h060, "full_pushpop_head");
        rxnew = 1'b0;
        reg_chk(2'd1, 32'h1002, "full_pushpop_status");
        reg_chk(2'd3, 32'h0, "full_pushpop_drops");
        for (int i = 1; i < 16; i++) pop_chk(32'h60 + 32'(i), "full_pushpop_drain");
        pop_chk(32'h055, "full_pushpop_last");

        // Threshold irq with thresh=4.
        wr(2'd2, 32'h0401);
        reg_chk(2'd2, 32'h0401, "ctrl_rb");
        push(8'hA0); push(8'hA1); push(8'hA2);
        step();
        chk("irq_cnt3", 32'(irq), 32'h0);
        push(8'hA3);
        chk("irq_latency", 32'(irq), 32'h0);
        step();
        chk("irq_cnt4", 32'(irq), 32'h1);
        pop_chk(32'h0A0, "irq_pop");
        chk("irq_pop_lat", 32'(irq), 32'h1);
        step();
        chk("irq_cnt3_again", 32'(irq), 32'h0);

        // Flush with a concurrent push at count 9.
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
        reg_chk(2'd1, 32'h0900, "pre_flush_status");
        rxnew = 1'b1; rxdata = 8'h77;
        wr(2'd2, 32'h8000_0100);
        rxnew = 1'b0;
        reg_chk(2'd1, 32'h001, "flush_status");
        reg_chk(2'd3, 32'h0, "flush_drops");
        reg_chk(2'd0, 32'h100, "flush_data");
        reg_chk(2'd2, 32'h100, "flush_ctrl");

        // Drop beats a same-cycle ovf clear and drop counter clear.
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        rxnew = 1'b1; rxdata = 8'hEE;
        wr(2'd1, 32'h4);
        reg_chk(2'd1, 32'h1006, "drop_vs_ovfclr");
        reg_chk(2'd3, 32'h1, "drop_vs_ovfclr_drops");
        wr(2'd3, 32'h0);
        rxnew = 1'b0;
        reg_chk(2'd3, 32'h1, "drop_vs_cntclr");

        // Overflow irq.
        wr(2'd2, 32'h0002);
        step();
        chk("irq_ovf", 32'(irq), 32'h1);
        wr(2'd1, 32'h4);
        step();
        chk("irq_ovf_clear", 32'(irq), 32'h0);

        // Asynchronous reset mid-stream.
        wr(2'd2, 32'h0403);
        step();
        chk("irq_pre_rst", 32'(irq), 32'h1);
        rxnew = 1'b1; rxdata = 8'h99;
        rst = 1'b1;
        #1;
        chk("rst_async_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 4; i++) reg_chk(vecs[i].a, vecs[i].exp_spo, "rst_async_regs");
        rxnew = 1'b0;
        step();
        rst = 1'b0;
        step();
        reg_chk(2'd1, 32'h001, "post_rst_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
